systolic_feeder: RTL and testbench

- Upstream feed stage for the MAC column.
- Accepts activation rows over a valid/ready handshake and buffers one tile of up to DEPTH rows.
- Streams the tile into the column with a diagonal skew: lane i is delayed i cycles. Drives the MAC's per-lane activation/valid inputs and a one-cycle clear before each tile.
- Signed data passes through unmodified.

---
 rtl/systolic_feeder_pkg.sv | 25 ++
 rtl/systolic_feeder_skew_delay.sv | 45 ++++
 rtl/systolic_feeder.sv | 135 +++++++++++++
 tb/tb_systolic_feeder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic feeder: FSM encoding, default sizes
// and the row-count width helper.
package systolic_feeder_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_LANES = 3;
    localparam int DEF_DEPTH = 8;

    // Width of one activation lane slice inside a packed row.
    localparam int LANE_W = DEF_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Row counter must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_delay.sv
// Per-lane skew line: delays data and valid by STAGES cycles.
// STAGES = 0 is a plain wire so lane 0 sees the head register directly.
module skew_delay #(
    parameter int W      = 8,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic         v,
    output logic [W-1:0] q,
    output logic         vq
);

    if (STAGES == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = clk ^ rst;
        assign q  = d;
        assign vq = v;
    end else begin : g_pipe
        logic [W-1:0]      dsr [STAGES];
        logic [STAGES-1:0] vsr;

        // Shift data and valid together; reset empties the line.
        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's value from before the clock edge.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < STAGES; s++) dsr[s] <= '0;
                vsr <= '0;
            end else begin
                dsr[0] <= d;
                vsr[0] <= v;
                for (int s = 1; s < STAGES; s++) begin
                    dsr[s] <= dsr[s-1];
                    vsr[s] <= vsr[s-1];
                end
            end
        end

        assign q  = dsr[STAGES-1];
        assign vq = vsr[STAGES-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Feed stage for the MAC column: buffers one tile of rows, then streams it
// out with lane i delayed by i cycles, preceded by a one-cycle clear.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int W     = LANE_W,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    input  logic               in_last,
    output logic [LANES*W-1:0] a_out,
    output logic [LANES-1:0]   valid_out,
    output logic               clear,
    output logic               busy,
    output logic               tile_done
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LANES - 1);

    state_t             state, state_nx;
    logic [CW-1:0]      count, count_nx;
    logic [CW-1:0]      rd, rd_nx;
    logic [DW-1:0]      dr, dr_nx;
    logic               accept, issue, done_nx, ready_nx;
    logic [PW-1:0]      wr_idx;
    logic [LANES*W-1:0] row_buf [DEPTH];
    logic [LANES*W-1:0] head_data;
    logic               head_valid;

    assign accept = in_valid && in_ready;
    // A tile's rows leave the buffer during CLEAR (row 0) and STREAM (rows 1..K-1).
    assign issue  = (state == ST_CLEAR) || (state == ST_STREAM);
    assign wr_idx = (state == ST_IDLE) ? '0 : count[PW-1:0];

    // Next-state, counters and next values of the registered outputs.
    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_nx = state;
        count_nx = count;
        rd_nx    = rd;
        dr_nx    = '0;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                rd_nx = '0;
                if (accept) begin
                    count_nx = CW'(1);
                    state_nx = in_last ? ST_CLEAR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    count_nx = count + 1'b1;
                    // in_last and a full buffer collapse into one end-of-tile event.
                    if (in_last || count_nx == DEPTH_C) state_nx = ST_CLEAR;
                end
            end
            ST_CLEAR, ST_STREAM: begin
                rd_nx    = rd + 1'b1;
                state_nx = (rd == count - 1'b1) ? ST_DRAIN : ST_STREAM;
            end
            ST_DRAIN: begin
                if (dr == DRAIN_LAST) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                    count_nx = '0;
                    rd_nx    = '0;
                end else begin
                    dr_nx = dr + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // in_ready stays low for the tile_done cycle and rises one cycle later.
        ready_nx = (state_nx == ST_LOAD) || (state_nx == ST_IDLE && state == ST_IDLE);
    end

    // State, counters, registered outputs and the skew-line head register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            rd         <= '0;
            dr         <= '0;
            in_ready   <= 1'b0;
            clear      <= 1'b0;
            busy       <= 1'b0;
            tile_done  <= 1'b0;
            head_data  <= '0;
            head_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            rd         <= rd_nx;
            dr         <= dr_nx;
            in_ready   <= ready_nx;
            clear      <= (state_nx == ST_CLEAR);
            busy       <= (state_nx != ST_IDLE);
            tile_done  <= done_nx;
            head_valid <= issue;
            head_data  <= issue ? row_buf[rd[PW-1:0]] : '0;
        end
    end

    // Row buffer write port.
    // NOTE: the buffer has no reset; each entry is written before it is read
    // within a tile, and a reset restarts the FSM so stale rows are never issued.
    always_ff @(posedge clk) begin
        if (accept) row_buf[wr_idx] <= in_data;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_delay #(
            .W      (W),
            .STAGES (i)
        ) u_skew (
            .clk (clk),
            .rst (rst),
            .d   (head_data[i*W +: W]),
            .v   (head_valid),
            .q   (a_out[i*W +: W]),
            .vq  (valid_out[i])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder.
module tb_systolic_feeder;

    localparam int W     = 8;
    localparam int LANES = 3;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] in_data;
    logic               in_last;
    logic [LANES*W-1:0] a_out;
    logic [LANES-1:0]   valid_out;
    logic               clear;
    logic               busy;
    logic               tile_done;

    int checks = 0;
    int errors = 0;

    logic [LANES*W-1:0] exp_rows [DEPTH];

    always #5 clk = ~clk;

    systolic_feeder #(.W(W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .a_out     (a_out),
        .valid_out (valid_out),
        .clear     (clear),
        .busy      (busy),
        .tile_done (tile_done)
    );

    function automatic logic [LANES*W-1:0] mk(input logic [7:0] l0, input logic [7:0] l1,
                                              input logic [7:0] l2);
        return {l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one row and hold it until accepted; returns in the cycle after acceptance.
    task automatic send_row(input logic [LANES*W-1:0] data, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (waited >= 50) begin
            errors++;
            $display("FAIL send_row_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (a_out !== '0 || valid_out !== '0 || clear !== 1'b0 || busy !== 1'b0 ||
            tile_done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: a_out=%h valid_out=%b clear=%b busy=%b tile_done=%b in_ready=%b, expected all 0",
                     name, a_out, valid_out, clear, busy, tile_done, in_ready);
        end
    endtask

    // Called in clear cycle C; checks every cycle through tile_done at C+K+LANES.
    task automatic check_stream(input string name, input int k);
        checks++;
        if (clear !== 1'b1 || valid_out !== '0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_clear_cycle: clear=%b valid_out=%b in_ready=%b busy=%b, expected 1 000 0 1",
                     name, clear, valid_out, in_ready, busy);
        end
        for (int j = 1; j <= k + LANES; j++) begin
            step();
            for (int i = 0; i < LANES; i++) begin
                int          r;
                logic        ev;
                logic [W-1:0] ed;
                r  = j - 1 - i;
                ev = (r >= 0) && (r < k);
                ed = '0;
                if (ev) ed = exp_rows[r][i*W +: W];
                checks++;
                if (valid_out[i] !== ev || a_out[i*W +: W] !== ed) begin
                    errors++;
                    $display("FAIL %s_lane%0d_C+%0d: valid=%b data=%h, expected valid=%b data=%h",
                             name, i, j, valid_out[i], a_out[i*W +: W], ev, ed);
                end
            end
            checks++;
            if (tile_done !== (j == k + LANES) || clear !== 1'b0 || in_ready !== 1'b0 ||
                busy !== (j < k + LANES)) begin
                errors++;
                $display("FAIL %s_ctrl_C+%0d: tile_done=%b clear=%b in_ready=%b busy=%b, expected %b 0 0 %b",
                         name, j, tile_done, clear, in_ready, busy, (j == k + LANES), (j < k + LANES));
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        #2 rst = 1'b0;
        #1;
        check_all_zero("reset_state");
        step();
        check_all_zero("reset_held");
        #3 rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || valid_out !== '0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b valid_out=%b, expected 1 0 000",
                     in_ready, busy, valid_out);
        end
    endtask

    task automatic test_basic();
        exp_rows[0] = mk(8'd1, 8'd2, 8'd3);
        exp_rows[1] = mk(8'd4, 8'd5, 8'd6);
        exp_rows[2] = mk(8'd7, 8'd8, 8'd9);
        send_row(exp_rows[0], 1'b0);
        send_row(exp_rows[1], 1'b0);
        send_row(exp_rows[2], 1'b1);
        check_stream("basic", 3);
    endtask

    task automatic test_signed();
        step();
        exp_rows[0] = mk(8'h80, 8'h7F, 8'hFF);
        send_row(exp_rows[0], 1'b1);
        check_stream("signed_k1", 1);
    endtask

    task automatic test_gaps();
        step();
        exp_rows[0] = mk(8'h11, 8'h12, 8'h13);
        exp_rows[1] = mk(8'h21, 8'h22, 8'h23);
        exp_rows[2] = mk(8'h31, 8'h32, 8'h33);
        send_row(exp_rows[0], 1'b0);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (clear !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL gaps_wait%0d: clear=%b busy=%b in_ready=%b, expected 0 1 1",
                         g, clear, busy, in_ready);
            end
            step();
        end
        send_row(exp_rows[1], 1'b0);
        checks++;
        if (clear !== 1'b0) begin
            errors++;
            $display("FAIL gaps_no_early_clear: clear=%b, expected 0", clear);
        end
        send_row(exp_rows[2], 1'b1);
        check_stream("gaps", 3);
    endtask

    task automatic test_full();
        logic [LANES*W-1:0] row9;
        step();
        for (int r = 0; r < DEPTH; r++) begin
            exp_rows[r] = mk(8'(10 + r), 8'(40 + r), 8'(8'hF0 + r));
            send_row(exp_rows[r], 1'b0);
        end
        row9 = mk(8'hA5, 8'h5A, 8'hC3);
        // Ninth row held on the bus through the whole stream; must not be taken.
        in_valid = 1'b1;
        in_data  = row9;
        in_last  = 1'b1;
        check_stream("full_depth", DEPTH);
        exp_rows[0] = row9;
        send_row(row9, 1'b1);
        check_stream("ninth_row", 1);
    endtask

    task automatic test_back_to_back();
        step();
        exp_rows[0] = mk(8'h01, 8'h02, 8'h03);
        exp_rows[1] = mk(8'hFE, 8'hFD, 8'hFC);
        send_row(exp_rows[0], 1'b0);
        send_row(exp_rows[1], 1'b1);
        check_stream("b2b_a", 2);
        exp_rows[0] = mk(8'h44, 8'h55, 8'h66);
        exp_rows[1] = mk(8'h77, 8'h88, 8'h99);
        send_row(exp_rows[0], 1'b0);
        send_row(exp_rows[1], 1'b1);
        check_stream("b2b_b", 2);
    endtask

    task automatic test_reset_mid();
        step();
        for (int r = 0; r < 4; r++) exp_rows[r] = mk(8'(r + 1), 8'(r + 2), 8'(r + 3));
        for (int r = 0; r < 4; r++) send_row(exp_rows[r], (r == 3));
        checks++;
        if (clear !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear: clear=%b, expected 1", clear);
        end
        step();
        step();
        checks++;
        if (valid_out === '0) begin
            errors++;
            $display("FAIL mid_streaming: valid_out=%b, expected nonzero", valid_out);
        end
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset_async");
        #2 rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release: busy=%b in_ready=%b, expected 0 1", busy, in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (valid_out !== '0 || a_out !== '0 || tile_done !== 1'b0 || clear !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_stale_%0d: valid_out=%b a_out=%h tile_done=%b clear=%b, expected 0",
                         c, valid_out, a_out, tile_done, clear);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_gaps();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
